serial_frame_router: RTL and testbench
======================================

# serial_frame_router

Serial front-end for the 1-to-4 bit demultiplexer. It receives framed serial traffic on one wire, decodes a 2-bit destination address from each frame header, and drives the demux select and data inputs for the payload bits. It checks the frame parity and reports frame completion, abort and parity error. It sits directly upstream of the demux: `sel` and `dout` connect to the demux `sel` and `in`.

## Interface
- `PAYLOAD_LEN`, default 8: payload bits per frame; legal range 1..255.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame start; high in the cycle `din` carries address bit 1 (MSB).
- `din`  in  1  serial frame bit.
- `sel`  out  2  destination channel to demux; registered.
- `dout`  out  1  payload bit to demux; registered; 0 outside payload.
- `dout_valid`  out  1  high when `dout` carries a payload bit.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `frame_done`  out  1  one-cycle pulse; frame completed.
- `parity_err`  out  1  one-cycle pulse, coincident with `frame_done`; parity mismatch.
- `frame_abort`  out  1  one-cycle pulse; frame cut short by a new `start`.

## Operation
- **Frame format on `din`:**
  - address bit 1 (with `start`);
  - address bit 0;
  - `PAYLOAD_LEN` payload bits, MSB first;
  - one parity bit.
  - Even parity: the XOR of 2 address bits, all payload bits and the parity bit must be 0.
- **State machine:**
  - IDLE: `start` → ADDR0; capture addr[1]; seed the parity accumulator.
  - ADDR0: capture addr[0]; load `sel` ← {addr[1], din} at the end of this cycle → PAYLOAD; clear the payload counter.
  - PAYLOAD: register `din` into `dout`; set `dout_valid`; increment the counter. On the count `PAYLOAD_LEN`-1 → PARITY.
  - PARITY: fold `din` into the accumulator → IDLE. Next cycle: pulse `frame_done`; pulse `parity_err` if the accumulator is non-zero.
- `sel` holds its last value between frames and changes only at ADDR0.
- `dout` = 0 and `dout_valid` = 0 whenever the cycle is not a payload cycle. As a result, all demux outputs are 0 between frames.
- `start` is ignored unless it arrives in IDLE or as an abort.
- **Abort:** `start` in ADDR0, PAYLOAD or PARITY abandons the current frame.
  - Pulse `frame_abort` the next cycle.
  - Force `dout`/`dout_valid` to 0 that cycle.
  - Capture addr[1] and go to ADDR0; the new frame proceeds normally.
  - No `frame_done` is issued for the aborted frame.
- **Counter width:** 8 bits, compared against `PAYLOAD_LEN`-1. No wrap inside a legal frame.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - state IDLE;
  - `sel` = 2'b00;
  - `dout`, `dout_valid`, `busy`, `frame_done`, `parity_err` and `frame_abort` all 0;
  - accumulator and counter cleared.
- Reset mid-frame discards the frame with no pulses.
- With `start` in cycle T:
  - `busy` is high from T+1 through T+2+`PAYLOAD_LEN`.
  - `sel` is valid from T+2.
  - Payload bit k on `din` at T+2+k appears on `dout` at T+3+k.
  - The parity bit is sampled at T+2+`PAYLOAD_LEN`.
  - `frame_done`/`parity_err` pulse at T+3+`PAYLOAD_LEN`, in the same cycle `busy` falls.
- Back-to-back frames: `start` is accepted at T+3+`PAYLOAD_LEN` (state IDLE). That cycle has `frame_done` high, `dout_valid` 0 and `busy` low.
- The last payload bit's `dout_valid` overlaps the PARITY state cycle. This is intended: one-cycle output latency.

## Structure
- Shared package `serial_frame_pkg` holds:
  - the state enum (IDLE, ADDR0, PAYLOAD, PARITY);
  - the `ADDR_W` = 2 constant;
  - the counter width constant `CNT_W` = 8.
- One sub-module is natural: `payload_counter` (clear, enable, terminal-count flag at `PAYLOAD_LEN`-1). The FSM, parity accumulator and output registers stay in the top.

## Test plan
- Reset mid-payload: assert `rst_n`=0 during bit 3 → all outputs 0 immediately, no pulses; after release, the next frame (addr 01, payload 8'hFF, parity 1) routes with `sel`=01.
- Nominal frame, `PAYLOAD_LEN`=8: addr 2'b10, payload 8'hA5, parity 1 → `sel`=10 from T+2; `dout` serial 1,0,1,0,0,1,0,1 at T+3..T+10 with `dout_valid`; `frame_done` at T+11; `parity_err`=0.
- Parity error: same frame with parity 0 → `frame_done` and `parity_err` both pulse at T+11.
- Back-to-back: second frame (addr 2'b11, payload 8'h0F, parity 0) with `start` at T+11 → `sel`=11 at T+13; no `dout_valid` gap violation; two `frame_done` pulses 11 cycles apart.
- Abort: `start` during payload bit 4 with new addr 2'b01 → `frame_abort` next cycle; `dout_valid` low that cycle; `sel`=01 one cycle later; no `frame_done` for the first frame; the new frame completes.
- `PAYLOAD_LEN`=1 boundary: addr 00, payload 1, parity 1 → one `dout_valid` cycle; `frame_done` at T+4; `parity_err`=0.

Source files
------------

// File: rtl/serial_frame_router_pkg.sv
// Shared types and constants for the serial frame router.
package serial_frame_pkg;

  localparam int ADDR_W = 2;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADDR0,
    PAYLOAD,
    PARITY
  } state_e;

endpackage

// File: rtl/serial_frame_router_if.sv
// Serial input plus demux-facing output bundle of the frame router.
interface serial_frame_router_if;
  import serial_frame_pkg::*;

  logic              start;
  logic              din;
  logic [ADDR_W-1:0] sel;
  logic              dout;
  logic              dout_valid;
  logic              busy;
  logic              frame_done;
  logic              parity_err;
  logic              frame_abort;

  modport master (
    output start, din,
    input  sel, dout, dout_valid, busy, frame_done, parity_err, frame_abort
  );

  modport slave (
    input  start, din,
    output sel, dout, dout_valid, busy, frame_done, parity_err, frame_abort
  );

endinterface

// File: rtl/serial_frame_router_payload_counter.sv
// Payload bit counter: synchronous clear, count enable, terminal-count flag
// at PAYLOAD_LEN-1.
module payload_counter
  import serial_frame_pkg::*;
#(
  parameter int PAYLOAD_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PAYLOAD_LEN - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/serial_frame_router.sv
// Serial frame front-end: decodes a 2-bit address, streams the payload to the
// demux and checks even parity over address, payload and parity bit.
//
// state   | meaning
// IDLE    | waiting for start; sel holds last destination
// ADDR0   | sampling address bit 0, loading sel
// PAYLOAD | forwarding payload bits to dout
// PARITY  | sampling parity bit, frame_done/parity_err next cycle
module serial_frame_router
  import serial_frame_pkg::*;
#(
  parameter int PAYLOAD_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_frame_router_if.slave  bus
);

  state_e            state_q;
  logic              addr1_q;
  logic              acc_q;
  logic [ADDR_W-1:0] sel_q;
  logic              dout_q;
  logic              dout_valid_q;
  logic              frame_done_q;
  logic              parity_err_q;
  logic              frame_abort_q;
  logic              cnt_tc;

  payload_counter #(
    .PAYLOAD_LEN (PAYLOAD_LEN)
  ) u_payload_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q == ADDR0),
    .en_i  (state_q == PAYLOAD),
    .tc_o  (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr1_q       <= 1'b0;
      acc_q         <= 1'b0;
      sel_q         <= '0;
      dout_q        <= 1'b0;
      dout_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      dout_q        <= 1'b0;
      dout_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      // A start outside IDLE abandons the running frame and begins a new one.
      if (bus.start) begin
        frame_abort_q <= (state_q != IDLE);
        addr1_q       <= bus.din;
        acc_q         <= bus.din;
        state_q       <= ADDR0;
      end else begin
        case (state_q)
          IDLE: ;
          ADDR0: begin
            sel_q   <= {addr1_q, bus.din};
            acc_q   <= acc_q ^ bus.din;
            state_q <= PAYLOAD;
          end
          PAYLOAD: begin
            dout_q       <= bus.din;
            dout_valid_q <= 1'b1;
            acc_q        <= acc_q ^ bus.din;
            if (cnt_tc) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            frame_done_q <= 1'b1;
            parity_err_q <= acc_q ^ bus.din;
            state_q      <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.sel         = sel_q;
  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_done  = frame_done_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.frame_abort = frame_abort_q;

endmodule

// File: tb/tb_serial_frame_router.sv
// Bench for serial_frame_router: frame-level reference model, per-cycle compare,
// directed frames plus randomized traffic for PAYLOAD_LEN 8 and 1.
module tb_serial_frame_router;

  localparam int NMAX = 700;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   nchk  = 0;
  int   nerr  = 0;

  bit         st [NMAX];
  bit         dn [NMAX];
  logic [1:0] e_sel [NMAX];
  bit         e_busy [NMAX], e_dv [NMAX], e_dout [NMAX], e_done [NMAX], e_err [NMAX], e_abort [NMAX];
  logic [1:0] g_sel [NMAX];
  bit         g_busy [NMAX], g_dv [NMAX], g_dout [NMAX], g_done [NMAX], g_err [NMAX], g_abort [NMAX];

  always #5 clk = ~clk;

  serial_frame_router_if bus8 ();
  serial_frame_router_if bus1 ();

  serial_frame_router #(.PAYLOAD_LEN(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_frame_router #(.PAYLOAD_LEN(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic chk(input string nm, input int c, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NMAX; i++) begin
      st[i] = 1'b0;
      dn[i] = 1'b0;
    end
  endtask

  task automatic put_frame(input int t, input int len, input logic [1:0] addr,
                           input logic [7:0] pay, input bit par);
    st[t]   = 1'b1;
    dn[t]   = addr[1];
    dn[t+1] = addr[0];
    for (int k = 0; k < len; k++) dn[t+2+k] = pay[len-1-k];
    dn[t+2+len] = par;
  endtask

  task automatic gen_random(input int len, input int n);
    int c;
    c = 2;
    for (int i = 0; i < NMAX; i++) begin
      st[i] = 1'b0;
      dn[i] = bit'($urandom_range(0, 1));
    end
    while (c + len + 6 < n) begin
      st[c] = 1'b1;
      if ($urandom_range(0, 4) == 0) c = c + 1 + int'($urandom_range(0, len + 1));
      else                           c = c + 3 + len + int'($urandom_range(0, 3));
    end
  endtask

  // Every start opens a frame; a frame is cut by the next start (abort) or by
  // a reset at cycle r, whichever comes first.
  task automatic build_model(input int len, input int n, input int r);
    int         starts [$];
    bit         ld [NMAX];
    logic [1:0] ldval [NMAX];
    logic [1:0] cur;
    int         t, e, last;
    bit         rcut, ab, par;
    for (int i = 0; i < NMAX; i++) begin
      e_sel[i] = 2'b00; e_busy[i] = 0; e_dv[i] = 0; e_dout[i] = 0;
      e_done[i] = 0; e_err[i] = 0; e_abort[i] = 0; ld[i] = 0; ldval[i] = 2'b00;
    end
    for (int i = 0; i < n; i++) if (st[i]) starts.push_back(i);
    if (r >= 0) begin
      ld[r+1]    = 1'b1;
      ldval[r+1] = 2'b00;
    end
    for (int i = 0; i < starts.size(); i++) begin
      t    = starts[i];
      e    = (i + 1 < starts.size()) ? starts[i+1] : (1 << 20);
      rcut = (r >= 0) && (t < r) && (r < e);
      if (rcut) e = r;
      ab   = (e <= t + 2 + len);
      last = (t + 2 + len < e) ? t + 2 + len : e;
      for (int c = t + 1; c <= last; c++) e_busy[c] = 1'b1;
      if (e > t + 1) begin
        ld[t+2]    = 1'b1;
        ldval[t+2] = {dn[t], dn[t+1]};
      end
      for (int k = 0; k < len; k++) begin
        if (t + 2 + k < e) begin
          e_dv[t+3+k]   = 1'b1;
          e_dout[t+3+k] = dn[t+2+k];
        end
      end
      if (!ab) begin
        par = 1'b0;
        for (int c = t; c <= t + 2 + len; c++) par ^= dn[c];
        e_done[t+3+len] = 1'b1;
        e_err[t+3+len]  = par;
      end else if (!rcut) begin
        e_abort[e+1] = 1'b1;
      end
    end
    cur = 2'b00;
    for (int c = 0; c < n; c++) begin
      if (ld[c]) cur = ldval[c];
      e_sel[c] = cur;
    end
  endtask

  task automatic snap(input int len, input int c);
    if (len == 8) begin
      g_sel[c] = bus8.sel; g_busy[c] = bus8.busy; g_dv[c] = bus8.dout_valid; g_dout[c] = bus8.dout;
      g_done[c] = bus8.frame_done; g_err[c] = bus8.parity_err; g_abort[c] = bus8.frame_abort;
    end else begin
      g_sel[c] = bus1.sel; g_busy[c] = bus1.busy; g_dv[c] = bus1.dout_valid; g_dout[c] = bus1.dout;
      g_done[c] = bus1.frame_done; g_err[c] = bus1.parity_err; g_abort[c] = bus1.frame_abort;
    end
  endtask

  task automatic drive(input int len, input bit s, input bit d);
    bus8.start = (len == 8) ? s : 1'b0;
    bus8.din   = (len == 8) ? d : 1'b0;
    bus1.start = (len == 1) ? s : 1'b0;
    bus1.din   = (len == 1) ? d : 1'b0;
  endtask

  task automatic run_phase(input int len, input int n, input int r);
    int sc;
    sc = NMAX - 1;
    build_model(len, n, r);
    rst_n = 1'b0;
    drive(len, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (r >= 0 && c == r + 1) rst_n = 1'b1;
      snap(len, c);
      chk("sel",         c, g_sel[c],   e_sel[c]);
      chk("busy",        c, g_busy[c],  e_busy[c]);
      chk("dout_valid",  c, g_dv[c],    e_dv[c]);
      chk("dout",        c, g_dout[c],  e_dout[c]);
      chk("frame_done",  c, g_done[c],  e_done[c]);
      chk("parity_err",  c, g_err[c],   e_err[c]);
      chk("frame_abort", c, g_abort[c], e_abort[c]);
      drive(len, st[c], dn[c]);
      if (c == r) begin
        #2 rst_n = 1'b0;
        #1 snap(len, sc);
        chk("async_rst_outputs", c,
            {g_sel[sc], g_busy[sc], g_dv[sc], g_dout[sc], g_done[sc], g_err[sc], g_abort[sc]}, 0);
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    int         cnt;
    drive(8, 1'b0, 1'b0);

    // Nominal, parity error, back-to-back, abort during payload bit 4.
    clear_stim();
    put_frame(2,  8, 2'b10, 8'hA5, 1'b1);
    put_frame(15, 8, 2'b10, 8'hA5, 1'b0);
    put_frame(28, 8, 2'b10, 8'hA5, 1'b1);
    put_frame(39, 8, 2'b11, 8'h0F, 1'b0);
    put_frame(52, 8, 2'b10, 8'hA5, 1'b1);
    put_frame(58, 8, 2'b01, 8'h3C, 1'b1);
    run_phase(8, 75, -1);
    chk("model_nominal_done", 13, e_done[13], 1);
    chk("model_parerr", 26, e_err[26], 1);
    chk("reset_busy", 0, g_busy[0], 0);
    chk("sel_before_load", 3, g_sel[3], 0);
    chk("nominal_sel", 4, g_sel[4], 2);
    b = 8'h00; cnt = 0;
    for (int k = 0; k < 8; k++) begin
      b = {b[6:0], g_dout[5+k]};
      cnt += int'(g_dv[5+k]);
    end
    chk("nominal_dout_byte", 5, b, 8'hA5);
    chk("nominal_dv_count", 5, cnt, 8);
    chk("nominal_done", 13, g_done[13], 1);
    chk("nominal_no_err", 13, g_err[13], 0);
    chk("parerr_done", 26, g_done[26], 1);
    chk("parerr_flag", 26, g_err[26], 1);
    chk("b2b_first_done", 39, g_done[39], 1);
    chk("b2b_dv_low", 39, g_dv[39], 0);
    chk("b2b_busy_low", 39, g_busy[39], 0);
    chk("b2b_sel", 41, g_sel[41], 3);
    chk("b2b_second_done", 50, g_done[50], 1);
    chk("abort_pulse", 59, g_abort[59], 1);
    chk("abort_dv_low", 59, g_dv[59], 0);
    chk("abort_new_sel", 60, g_sel[60], 1);
    chk("aborted_no_done", 63, g_done[63], 0);
    chk("after_abort_done", 69, g_done[69], 1);

    // Reset during payload bit 3 of the first frame.
    clear_stim();
    put_frame(2,  8, 2'b10, 8'hA5, 1'b1);
    put_frame(12, 8, 2'b01, 8'hFF, 1'b1);
    run_phase(8, 30, 7);
    chk("rst_busy_after", 8, g_busy[8], 0);
    chk("rst_old_no_done", 13, g_done[13], 0);
    chk("rst_new_sel", 14, g_sel[14], 1);
    chk("rst_new_done", 23, g_done[23], 1);
    chk("rst_new_no_err", 23, g_err[23], 0);

    // PAYLOAD_LEN = 1 boundary.
    clear_stim();
    put_frame(2, 1, 2'b00, 8'h01, 1'b1);
    run_phase(1, 12, -1);
    cnt = 0;
    for (int c = 0; c < 12; c++) cnt += int'(g_dv[c]);
    chk("len1_dv_count", 5, cnt, 1);
    chk("len1_dout", 5, g_dout[5], 1);
    chk("len1_done", 6, g_done[6], 1);
    chk("len1_no_err", 6, g_err[6], 0);

    gen_random(8, 600);
    run_phase(8, 600, -1);
    gen_random(1, 300);
    run_phase(1, 300, -1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
